// File: rtl/display_arbiter.sv
// Round-robin arbiter that time-shares the 8-digit display between four requesters,
// holding each grant for a minimum dwell and registering the owner's nibbles for seg0..seg7.
`timescale 1ns/1ps
module display_arbiter #(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        active,
  output logic [3:0]  seg0,
  output logic [3:0]  seg1,
  output logic [3:0]  seg2,
  output logic [3:0]  seg3,
  output logic [3:0]  seg4,
  output logic [3:0]  seg5,
  output logic [3:0]  seg6,
  output logic [3:0]  seg7
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic             active_nxt;
  logic [1:0]       win;
  logic [3:0]       others;
  logic             take;
  logic [31:0]      owner_data_p0;
  logic [31:0]      seg_word_p1;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Scan from farthest to nearest so the nearest requester after base overrides;
  // base itself is visited as the farthest candidate and thus wins only when alone.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    win        = rr_pick(req, last);
    others     = req & ~onehot(owner);
    take       = 1'b0;
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    active_nxt = active;

    unique case (state)
      IDLE: begin
        gnt_nxt    = '0;
        active_nxt = 1'b0;
        if (req != 4'b0000) take = 1'b1;
      end
      HOLD: begin
        if (!req[owner]) begin
          if (req != 4'b0000) begin
            take = 1'b1;
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            active_nxt = 1'b0;
          end
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (others != 4'b0000) begin
          take = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      state_nxt  = HOLD;
      owner_nxt  = win;
      last_nxt   = win;
      cnt_nxt    = RELOAD;
      gnt_nxt    = onehot(win);
      active_nxt = 1'b1;
    end
  end

  // Stage p0: select the registered owner's live data word
  always_comb begin
    case (owner)
      2'd0:    owner_data_p0 = data0;
      2'd1:    owner_data_p0 = data1;
      2'd2:    owner_data_p0 = data2;
      default: owner_data_p0 = data3;
    endcase
  end

  // Stage p1: control registers and the display word; seg holds while idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      active      <= 1'b0;
      last        <= 2'd3;
      cnt         <= '0;
      seg_word_p1 <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      owner  <= owner_nxt;
      active <= active_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      if (active) seg_word_p1 <= owner_data_p0;
    end
  end

  assign seg0 = seg_word_p1[3:0];
  assign seg1 = seg_word_p1[7:4];
  assign seg2 = seg_word_p1[11:8];
  assign seg3 = seg_word_p1[15:12];
  assign seg4 = seg_word_p1[19:16];
  assign seg5 = seg_word_p1[23:20];
  assign seg6 = seg_word_p1[27:24];
  assign seg7 = seg_word_p1[31:28];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a cycle model pushes expected outputs each edge,
// a monitor pops and compares on the falling edge; directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_display_arbiter;
  localparam int DWELL = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        active;
  logic [3:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [31:0] seg_all;

  display_arbiter #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .gnt(gnt), .owner(owner), .active(active),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;
  assign seg_all = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        active;
    logic        chk_own;
    logic [31:0] seg;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int i);
    case (i)
      0:       return data0;
      1:       return data1;
      2:       return data2;
      default: return data3;
    endcase
  endfunction

  // First requester found walking forward from the one after 'from'; -1 if none.
  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  // Reference model: owner, pointer, and how many edges the current grant has been shown.
  logic        m_act = 1'b0;
  int          m_own = 0, m_last = 3, m_held = 0, m_win;
  logic [31:0] m_seg = '0;
  exp_t        m_e;

  always @(posedge clk) begin
    if (!reset) begin
      m_act = 1'b0; m_own = 0; m_last = 3; m_held = 0; m_seg = '0;
    end else begin
      if (m_act) m_seg = data_of(m_own);
      m_win = pick(req, m_last);
      if (!m_act) begin
        if (m_win >= 0) begin m_act = 1'b1; m_own = m_win; m_last = m_win; m_held = 1; end
      end else if (!req[m_own]) begin
        if (m_win >= 0) begin m_own = m_win; m_last = m_win; m_held = 1; end
        else m_act = 1'b0;
      end else if (m_held < DWELL) begin
        m_held++;
      end else if (m_win != m_own) begin
        m_own = m_win; m_last = m_win; m_held = 1;
      end
    end
    m_e.gnt     = m_act ? 4'(1 << m_own) : 4'b0000;
    m_e.owner   = 2'(m_own);
    m_e.active  = m_act;
    m_e.chk_own = m_act || !reset;
    m_e.seg     = m_seg;
    sb.push_back(m_e);
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
      chk("sb_active", 32'(active), 32'(mon_e.active));
      if (mon_e.chk_own) chk("sb_owner", 32'(owner), 32'(mon_e.owner));
      chk("sb_seg", seg_all, mon_e.seg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 4'b0000;
    tick(3);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    data0 = 32'h1234_ABCD; data1 = 32'h1111_1111; data2 = 32'h2222_2222; data3 = 32'h3333_3333;
    reset = 1'b0; req = 4'b0000;
    tick(3);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_seg", seg_all, 32'h0);

    // Reset release and first grant
    reset = 1'b1; req = 4'b0101;
    tick(1); chk("t1_gnt", 32'(gnt), 32'h1);
    tick(1); chk("t1_seg", seg_all, 32'h1234_ABCD);
    tick(8);

    // Dwell with a competitor arriving one cycle later
    do_reset();
    req = 4'b0001; tick(1);
    req = 4'b0101; tick(3); chk("t2_hold", 32'(gnt), 32'h1);
    tick(1); chk("t2_switch", 32'(gnt), 32'h4);
    tick(4);

    // Early release with and without another requester
    do_reset();
    req = 4'b0010; tick(1);
    req = 4'b1010; tick(1);
    req = 4'b1000; tick(1); chk("t3_early", 32'(gnt), 32'h8);
    tick(2);
    req = 4'b0000; tick(1); chk("t3_idle_gnt", 32'(gnt), 32'h0);
    tick(3); chk("t3_idle_act", 32'(active), 32'h0);
    chk("t3_seg_hold", seg_all, 32'h3333_3333);

    // Fair rotation
    do_reset();
    req = 4'hF; tick(20);

    // Sole owner past dwell, then a newcomer switches immediately
    do_reset();
    req = 4'b0100; tick(12); chk("t5_keep", 32'(gnt), 32'h4);
    req = 4'b0101; tick(1); chk("t5_switch", 32'(gnt), 32'h1);
    tick(3);

    // Reset mid-dwell
    do_reset();
    req = 4'b1000; tick(2);
    reset = 1'b0; tick(1);
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_active", 32'(active), 32'h0);
    chk("t6_seg", seg_all, 32'h0);
    reset = 1'b1; req = 4'hF; tick(1); chk("t6_first", 32'(gnt), 32'h1);
    tick(5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: data0 = $urandom;
          1: data1 = $urandom;
          2: data2 = $urandom;
          default: data3 = $urandom;
        endcase
      end
      reset = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    reset = 1'b1; req = 4'b0000;
    tick(3);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
